// File: rtl/prog_suite_sequencer_if.sv
// ---------------------------------------------------------------------------
// prog_suite_sequencer_if
// Bundles every non-clock/reset signal of the program-suite sequencer.
//   master : the sequencer itself (drives launch, memory address, results)
//   slave  : the environment (processor, DUT memory, golden image, host)
// Signals:
//   go                  start a suite (host -> sequencer)
//   range_lo/range_hi   packed per-program inclusive check ranges
//   dut_start/dut_ack   launch pulse / done level with the processor
//   mem_addr            shared read address, data returns one cycle later
//   dut_rd_data/gold_rd_data  read data from DUT memory and golden image
//   busy, result_*, done, pass  status and per-program results
// ---------------------------------------------------------------------------
interface prog_suite_sequencer_if #(
    parameter int NUM_PROGS = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int ERR_W     = 8,
    parameter int CYC_W     = 16
);
    localparam int PROG_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

    logic                        go;
    logic [NUM_PROGS*ADDR_W-1:0] range_lo;
    logic [NUM_PROGS*ADDR_W-1:0] range_hi;
    logic                        dut_start;
    logic                        dut_ack;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           dut_rd_data;
    logic [DATA_W-1:0]           gold_rd_data;
    logic                        busy;
    logic                        result_valid;
    logic [PROG_W-1:0]           result_prog;
    logic [ERR_W-1:0]            result_errs;
    logic [CYC_W-1:0]            result_cycles;
    logic                        result_timeout;
    logic                        done;
    logic                        pass;

    modport master (
        input  go, range_lo, range_hi, dut_ack, dut_rd_data, gold_rd_data,
        output dut_start, mem_addr, busy, result_valid, result_prog,
               result_errs, result_cycles, result_timeout, done, pass
    );

    modport slave (
        output go, range_lo, range_hi, dut_ack, dut_rd_data, gold_rd_data,
        input  dut_start, mem_addr, busy, result_valid, result_prog,
               result_errs, result_cycles, result_timeout, done, pass
    );
endinterface

// File: rtl/prog_suite_sequencer.sv
// ---------------------------------------------------------------------------
// prog_suite_sequencer
// Runs a suite of NUM_PROGS programs on a processor: launches each program,
// waits for a fresh done acknowledge (with timeout), then walks an address
// range comparing DUT memory against a golden image and reports the
// mismatch count and cycle count per program.  Done/Pass summarise the suite.
// Ports:
//   i_clk    clock, all state on rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      prog_suite_sequencer_if master modport (see interface file)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | after reset, waiting for go
// S_LAUNCH   | dut_start high this cycle, counters cleared, detector disarmed
// S_WAIT_ACK | counting cycles; arm on ack low, accept on armed ack high
// S_CHECK    | issue lo..hi addresses, compare returned data one cycle later
// S_REPORT   | result_valid high for one cycle
// S_DONE     | suite finished, done/pass held until next go
// ---------------------------------------------------------------------------
module prog_suite_sequencer #(
    parameter int NUM_PROGS = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int ERR_W     = 8,
    parameter int CYC_W     = 16,
    parameter int TIMEOUT   = 20000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    prog_suite_sequencer_if.master bus
);
    localparam int                PROG_W    = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
    localparam logic [CYC_W-1:0]  CYC_MAX   = '1;
    localparam logic [CYC_W:0]    TIMEOUT_C = (CYC_W+1)'(TIMEOUT);
    localparam logic [PROG_W-1:0] LAST_PROG = PROG_W'(NUM_PROGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_CHECK,
        S_REPORT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [PROG_W-1:0]  r_idx;
    logic [CYC_W-1:0]   r_cyc;
    logic [ERR_W-1:0]   r_errs;
    logic               r_armed;
    logic               r_pass_acc;
    logic [ADDR_W:0]    r_cur;       // one extra bit so hi = max address ends cleanly
    logic               r_issuing;
    logic               r_cmp_valid;

    logic               r_dut_start;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_busy;
    logic               r_result_valid;
    logic [PROG_W-1:0]  r_result_prog;
    logic [ERR_W-1:0]   r_result_errs;
    logic [CYC_W-1:0]   r_result_cycles;
    logic               r_result_timeout;
    logic               r_done;
    logic               r_pass;

    logic [ADDR_W-1:0]  w_lo;
    logic [ADDR_W-1:0]  w_hi;
    logic [ADDR_W:0]    w_lo_ext;
    logic [ADDR_W:0]    w_hi_ext;
    logic [DATA_W-1:0]  w_dut_data;
    logic [DATA_W-1:0]  w_gold_data;
    logic [CYC_W-1:0]   w_cyc_next;
    logic               w_timeout_hit;
    logic               w_mismatch;
    logic [ERR_W-1:0]   w_errs_upd;

    assign w_lo        = bus.range_lo[r_idx*ADDR_W +: ADDR_W];
    assign w_hi        = bus.range_hi[r_idx*ADDR_W +: ADDR_W];
    assign w_lo_ext    = {1'b0, w_lo};
    assign w_hi_ext    = {1'b0, w_hi};
    assign w_dut_data  = bus.dut_rd_data;
    assign w_gold_data = bus.gold_rd_data;

    assign w_cyc_next    = (r_cyc == CYC_MAX) ? r_cyc : r_cyc + 1'b1;
    assign w_timeout_hit = ({1'b0, w_cyc_next} >= TIMEOUT_C);

    // Data on the read ports belongs to the address driven last cycle.
    assign w_mismatch = r_cmp_valid && (w_dut_data != w_gold_data);
    assign w_errs_upd = (w_mismatch && (r_errs != ERR_MAX)) ? r_errs + 1'b1 : r_errs;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_idx            <= '0;
            r_cyc            <= '0;
            r_errs           <= '0;
            r_armed          <= 1'b0;
            r_pass_acc       <= 1'b0;
            r_cur            <= '0;
            r_issuing        <= 1'b0;
            r_cmp_valid      <= 1'b0;
            r_dut_start      <= 1'b0;
            r_mem_addr       <= '0;
            r_busy           <= 1'b0;
            r_result_valid   <= 1'b0;
            r_result_prog    <= '0;
            r_result_errs    <= '0;
            r_result_cycles  <= '0;
            r_result_timeout <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
        end else begin
            r_dut_start    <= 1'b0;
            r_result_valid <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.go) begin
                        r_state     <= S_LAUNCH;
                        r_idx       <= '0;
                        r_cyc       <= '0;
                        r_errs      <= '0;
                        r_armed     <= 1'b0;
                        r_pass_acc  <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_dut_start <= 1'b1;
                    end
                end

                S_LAUNCH: begin
                    r_cyc   <= '0;
                    r_errs  <= '0;
                    r_armed <= 1'b0;
                    r_state <= S_WAIT_ACK;
                end

                S_WAIT_ACK: begin
                    r_cyc <= w_cyc_next;
                    // A level left high by the previous program must go low
                    // once before it can count as this program's ack.
                    if (!r_armed && !bus.dut_ack) begin
                        r_armed <= 1'b1;
                    end
                    if (r_armed && bus.dut_ack) begin
                        r_state     <= S_CHECK;
                        r_mem_addr  <= w_lo;
                        r_cur       <= w_lo_ext;
                        r_issuing   <= (w_lo_ext <= w_hi_ext);
                        r_cmp_valid <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_state          <= S_REPORT;
                        r_errs           <= ERR_MAX;
                        r_result_valid   <= 1'b1;
                        r_result_prog    <= r_idx;
                        r_result_errs    <= ERR_MAX;
                        r_result_cycles  <= w_cyc_next;
                        r_result_timeout <= 1'b1;
                        r_pass_acc       <= 1'b0;
                    end
                end

                S_CHECK: begin
                    r_errs <= w_errs_upd;
                    if (r_issuing) begin
                        r_cmp_valid <= 1'b1;
                        if (r_cur < w_hi_ext) begin
                            r_cur      <= r_cur + 1'b1;
                            r_mem_addr <= r_mem_addr + 1'b1;
                        end else begin
                            // hi issued; hold one cycle to compare its data
                            r_issuing <= 1'b0;
                        end
                    end else begin
                        r_cmp_valid      <= 1'b0;
                        r_state          <= S_REPORT;
                        r_result_valid   <= 1'b1;
                        r_result_prog    <= r_idx;
                        r_result_errs    <= w_errs_upd;
                        r_result_cycles  <= r_cyc;
                        r_result_timeout <= 1'b0;
                        if (w_errs_upd != '0) begin
                            r_pass_acc <= 1'b0;
                        end
                    end
                end

                S_REPORT: begin
                    if (r_idx != LAST_PROG) begin
                        r_idx       <= r_idx + 1'b1;
                        r_state     <= S_LAUNCH;
                        r_dut_start <= 1'b1;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= r_pass_acc;
                        r_busy  <= 1'b0;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dut_start      = r_dut_start;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.busy           = r_busy;
    assign bus.result_valid   = r_result_valid;
    assign bus.result_prog    = r_result_prog;
    assign bus.result_errs    = r_result_errs;
    assign bus.result_cycles  = r_result_cycles;
    assign bus.result_timeout = r_result_timeout;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
endmodule

// File: doc/prog_suite_sequencer.md
PROG_SUITE_SEQUENCER -- requirements
Module: prog_suite_sequencer

Interface
REQ-001 SHALL have parameter NUM_PROGS, default 3, number of programs run per suite.
REQ-002 SHALL have parameter ADDR_W, default 8, data-memory address width.
REQ-003 SHALL have parameter DATA_W, default 8, data-memory word width.
REQ-004 SHALL have parameter ERR_W, default 8, per-program mismatch counter width.
REQ-005 SHALL have parameter CYC_W, default 16, per-program cycle counter width.
REQ-006 SHALL have parameter TIMEOUT, default 20000, max cycles to wait for DutAck.
REQ-007 Clk  in  1  single clock; all state on rising edge.
REQ-008 ResetN  in  1  asynchronous, active-low reset.
REQ-009 Go  in  1  start suite; sampled in IDLE and DONE only.
REQ-010 RangeLo  in  NUM_PROGS*ADDR_W  per-program first check address; program k at bits [k*ADDR_W +: ADDR_W].
REQ-011 RangeHi  in  NUM_PROGS*ADDR_W  per-program last check address, inclusive.
REQ-012 DutStart  out  1  one-cycle launch pulse to processor.
REQ-013 DutAck  in  1  processor done flag (level).
REQ-014 MemAddr  out  ADDR_W  shared read address to DUT memory and golden image.
REQ-015 DutRdData  in  DATA_W  DUT memory read data, valid 1 cycle after MemAddr.
REQ-016 GoldRdData  in  DATA_W  golden read data, valid 1 cycle after MemAddr.
REQ-017 Busy  out  1  high from leaving IDLE/DONE until DONE entered.
REQ-018 ResultValid  out  1  one-cycle pulse per finished program.
REQ-019 ResultProg  out  $clog2(NUM_PROGS) (min 1)  program index of current result.
REQ-020 ResultErrs  out  ERR_W  mismatch count of that program.
REQ-021 ResultCycles  out  CYC_W  cycles from DutStart pulse to accepted DutAck.
REQ-022 ResultTimeout  out  1  program hit TIMEOUT.
REQ-023 Done  out  1  sticky suite-complete level.
REQ-024 Pass  out  1  valid with Done; all programs zero errors and no timeout.

Function
REQ-025 States SHALL be IDLE, LAUNCH, WAIT_ACK, CHECK, REPORT, DONE.
REQ-026 IDLE/DONE with Go=1 SHALL go to LAUNCH with program index 0, clear Done, Pass, all counters; Go elsewhere ignored.
REQ-027 LAUNCH SHALL assert DutStart exactly one cycle, clear cycle counter, disarm ack detector, go to WAIT_ACK.
REQ-028 WAIT_ACK SHALL arm once DutAck sampled low; stale high Ack before arming ignored.
REQ-029 Armed and DutAck=1 SHALL go to CHECK; cycle counter increments every WAIT_ACK cycle, saturating at 2^CYC_W-1.
REQ-030 Cycle counter reaching TIMEOUT before accepted Ack SHALL set timeout flag, force errs to 2^ERR_W-1, skip CHECK, go to REPORT.
REQ-031 CHECK SHALL drive MemAddr=Lo on first cycle, increment by 1 per cycle through Hi, then hold one extra cycle for last compare; duration Hi-Lo+2 cycles.
REQ-032 Each compare SHALL use data returned for the address issued the previous cycle; DutRdData!=GoldRdData increments errs, saturating at 2^ERR_W-1.
REQ-033 Address iteration SHALL use ADDR_W+1-bit compare so Hi=2^ADDR_W-1 terminates without wrap.
REQ-034 Hi<Lo SHALL check zero addresses, errs=0, CHECK lasts 1 cycle.
REQ-035 REPORT SHALL pulse ResultValid one cycle with ResultProg/Errs/Cycles/Timeout stable that cycle; result outputs hold until next REPORT.
REQ-036 After REPORT: index<NUM_PROGS-1 -> increment index, LAUNCH; else DONE.
REQ-037 Pass SHALL accumulate as AND over programs of (errs==0 && !timeout); Done and Pass set on entering DONE and hold until next accepted Go.
REQ-038 DutAck dropping during CHECK/REPORT SHALL have no effect.

Reset
REQ-039 ResetN low SHALL immediately force IDLE; DutStart, Busy, ResultValid, ResultTimeout, Done, Pass = 0; MemAddr, ResultProg, ResultErrs, ResultCycles, counters, index = 0; detector disarmed.
REQ-040 ResetN low mid-suite SHALL abandon the suite with no ResultValid; restart requires new Go.

Verification
REQ-041 Ranges {30..59, 94..123, 192..194}, golden=DUT, Ack 50 cycles after each Start -> 3 ResultValid pulses, errs 0, cycles 50, Done=1, Pass=1.
REQ-042 Same, DUT[40] and DUT[100] corrupted -> prog0 errs=1, prog1 errs=1, prog2 errs=0, Pass=0.
REQ-043 Ack held high from previous program, drops 2 cycles after Start, rises 10 later -> stale Ack ignored, cycles=12.
REQ-044 TIMEOUT=100, Ack never rises on prog1 -> prog1 ResultTimeout=1, errs=255, no CHECK addresses issued, prog2 still runs, Pass=0.
REQ-045 Prog2 range 255..255, then 5..4 -> one compare at address 255 without wrap; empty range errs=0.
REQ-046 ResetN low during prog1 CHECK -> all outputs 0 asynchronously; Go after release runs full suite from prog0.
